display_scan_sequencer: RTL and testbench

//   Parametrised digit-scan sequencer for multiplexed 7-segment displays.

---
 rtl/display_pkg.sv | 23 ++
 rtl/scan_prescaler.sv | 40 ++++
 rtl/display_scan_sequencer.sv | 134 +++++++++++++
 tb/tb_display_scan_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared helpers for the multiplexed 7-segment display scan logic.
//   sel_width       : index width for a count of items (at least 1 bit)
//   anode_off_level : electrical level that turns one anode off
//   anode_drive     : maps a logical "anode on" bit to its electrical level
// -----------------------------------------------------------------------------
package display_pkg;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic anode_off_level(input logic active_low);
    return active_low;
  endfunction

  // Applied per anode bit so the helper stays independent of digit count.
  function automatic logic anode_drive(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Slot-rate prescaler: counts 0..PRESCALE-1 while enabled, holds otherwise.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   enable in  1: count; 0: hold
//   cnt    out current position inside the slot
//   tc     out terminal count while enabled (the slot advance event)
// -----------------------------------------------------------------------------
module scan_prescaler
  import display_pkg::*;
#(
  parameter  int PRESCALE = 50000,
  localparam int CW       = sel_width(PRESCALE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  // Gated by enable so a terminal count coinciding with enable falling
  // does not advance the scan.
  assign tc = enable && (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments and resets
  // asynchronously; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan_sequencer.sv
// -----------------------------------------------------------------------------
// display_scan_sequencer
// Digit-scan sequencer for multiplexed 7-segment displays: steps through the
// enabled digits one slot at a time, blanks the anodes at the start of each
// slot to suppress ghosting, and marks the start of each frame.
// Ports:
//   clk         in  system clock
//   reset       in  asynchronous active-high reset
//   enable      in  1: scanning runs; 0: frozen and dark
//   digit_mask  in  per-digit enable, 0 = skipped
//   digit_sel   out index of the current digit (segment data mux select)
//   anode       out one-hot anode drive, polarity set by ANODE_ACTIVE_LOW
//   blank       out 1 while anodes are forced off
//   frame_start out 1-cycle pulse on entering the lowest enabled digit
// -----------------------------------------------------------------------------
module display_scan_sequencer
  import display_pkg::*;
#(
  parameter  int NUM_DIGITS       = 4,
  parameter  int PRESCALE         = 50000,
  parameter  int BLANK_CYCLES     = 500,
  parameter  bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int DW               = sel_width(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [DW-1:0]         digit_sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  blank,
  output logic                  frame_start
);

  localparam int CW = sel_width(PRESCALE);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    {NUM_DIGITS{anode_off_level(ANODE_ACTIVE_LOW)}};

  logic [CW-1:0]         cnt;
  logic                  tc;
  logic [CW-1:0]         cnt_nxt;
  logic [DW-1:0]         sel_nxt;
  logic                  blank_run;
  logic [NUM_DIGITS-1:0] anode_nxt;
  logic                  blank_nxt;
  logic                  frame_nxt;

  // Next enabled index after cur, searching circularly; returns cur when it
  // is the only enabled digit and holds cur when nothing is enabled. The
  // extra index bit keeps the wrap correct for non-power-of-2 counts.
  function automatic logic [DW-1:0] next_enabled(input logic [DW-1:0]         cur,
                                                 input logic [NUM_DIGITS-1:0] mask);
    logic [DW-1:0] result;
    logic [DW:0]   idx;
    logic          found;
    result = cur;
    found  = 1'b0;
    for (int step = 1; step <= NUM_DIGITS; step++) begin
      idx = {1'b0, cur} + (DW+1)'(step);
      if (idx >= (DW+1)'(NUM_DIGITS)) idx = idx - (DW+1)'(NUM_DIGITS);
      if (!found && mask[idx[DW-1:0]]) begin
        result = idx[DW-1:0];
        found  = 1'b1;
      end
    end
    return result;
  endfunction

  function automatic logic [DW-1:0] lowest_enabled(input logic [NUM_DIGITS-1:0] mask);
    logic [DW-1:0] result;
    result = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) result = DW'(i);
    end
    return result;
  endfunction

  scan_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .cnt    (cnt),
    .tc     (tc)
  );

  // Mirror of the prescaler's next count so blank/anode can be registered
  // coherently with the slot that digit_sel enters on the same edge.
  assign cnt_nxt = tc ? '0 : (enable ? cnt + CW'(1) : cnt);

  // The mask is sampled only at the advance event.
  assign sel_nxt = tc ? next_enabled(digit_sel, digit_mask) : digit_sel;

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank_run = 1'b0;
  end else begin : g_blank
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);
    assign blank_run = (cnt_nxt < BLANK_CNT);
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    anode_nxt = ANODE_OFF;
    blank_nxt = 1'b1;
    frame_nxt = 1'b0;
    if (enable) begin
      blank_nxt = blank_run;
      frame_nxt = tc && (|digit_mask) && (sel_nxt == lowest_enabled(digit_mask));
      // Live mask bit here, so clearing the current digit darkens it at once.
      if (!blank_run && digit_mask[sel_nxt]) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          anode_nxt[i] = anode_drive(sel_nxt == DW'(i), ANODE_ACTIVE_LOW);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_sel   <= '0;
      anode       <= ANODE_OFF;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      digit_sel   <= sel_nxt;
      anode       <= anode_nxt;
      blank       <= blank_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_display_scan_sequencer
// Directed bench: main instance with 4 digits, prescale 4, 1 blank cycle,
// active-low anodes; second instance with 3 digits, prescale 3, no blanking.
// -----------------------------------------------------------------------------
module tb_display_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable;
  logic [3:0] digit_mask;
  logic [1:0] digit_sel;
  logic [3:0] anode;
  logic       blank;
  logic       frame_start;

  logic       enable3;
  logic [2:0] digit_mask3;
  logic [1:0] digit_sel3;
  logic [2:0] anode3;
  logic       blank3;
  logic       frame_start3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_scan_sequencer #(
    .NUM_DIGITS       (4),
    .PRESCALE         (4),
    .BLANK_CYCLES     (1),
    .ANODE_ACTIVE_LOW (1'b1)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .digit_mask  (digit_mask),
    .digit_sel   (digit_sel),
    .anode       (anode),
    .blank       (blank),
    .frame_start (frame_start)
  );

  display_scan_sequencer #(
    .NUM_DIGITS       (3),
    .PRESCALE         (3),
    .BLANK_CYCLES     (0),
    .ANODE_ACTIVE_LOW (1'b1)
  ) u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable3),
    .digit_mask  (digit_mask3),
    .digit_sel   (digit_sel3),
    .anode       (anode3),
    .blank       (blank3),
    .frame_start (frame_start3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles on the main instance, checking all outputs each cycle.
  task automatic run_vec(input string tag, input int n, input logic [1:0] sel,
                         input logic [3:0] an, input logic fs, input logic bl);
    repeat (n) begin
      @(negedge clk);
      check({tag, ".sel"},   32'(digit_sel),   32'(sel));
      check({tag, ".anode"}, 32'(anode),       32'(an));
      check({tag, ".frame"}, 32'(frame_start), 32'(fs));
      check({tag, ".blank"}, 32'(blank),       32'(bl));
    end
  endtask

  initial begin
    enable      = 1'b1;
    digit_mask  = 4'b1111;
    enable3     = 1'b1;
    digit_mask3 = 3'b111;
    #1 reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst.sel",   32'(digit_sel),   32'd0);
    check("rst.anode", 32'(anode),       32'hF);
    check("rst.blank", 32'(blank),       32'd1);
    check("rst.frame", 32'(frame_start), 32'd0);
    reset = 1'b0;

    // 1: full mask, digits 0..3 then wrap to 0
    run_vec("t1", 3, 2'd0, 4'hE, 1'b0, 1'b0);
    run_vec("t1", 1, 2'd1, 4'hF, 1'b0, 1'b1);
    run_vec("t1", 3, 2'd1, 4'hD, 1'b0, 1'b0);
    run_vec("t1", 1, 2'd2, 4'hF, 1'b0, 1'b1);
    run_vec("t1", 3, 2'd2, 4'hB, 1'b0, 1'b0);
    run_vec("t1", 1, 2'd3, 4'hF, 1'b0, 1'b1);
    run_vec("t1", 3, 2'd3, 4'h7, 1'b0, 1'b0);
    run_vec("t1", 1, 2'd0, 4'hF, 1'b1, 1'b1);
    run_vec("t1", 1, 2'd0, 4'hE, 1'b0, 1'b0);

    // 2: mask 1010 mid-slot; digit 0 goes dark at once, then 1,3,1,3
    digit_mask = 4'b1010;
    run_vec("t2", 2, 2'd0, 4'hF, 1'b0, 1'b0);
    run_vec("t2", 1, 2'd1, 4'hF, 1'b1, 1'b1);
    run_vec("t2", 3, 2'd1, 4'hD, 1'b0, 1'b0);
    run_vec("t2", 1, 2'd3, 4'hF, 1'b0, 1'b1);
    run_vec("t2", 3, 2'd3, 4'h7, 1'b0, 1'b0);
    run_vec("t2", 1, 2'd1, 4'hF, 1'b1, 1'b1);
    run_vec("t2", 3, 2'd1, 4'hD, 1'b0, 1'b0);
    run_vec("t2", 1, 2'd3, 4'hF, 1'b0, 1'b1);

    // 3: empty mask holds digit 3 dark; then mask 0100 lands on 2
    digit_mask = 4'b0000;
    run_vec("t3", 3, 2'd3, 4'hF, 1'b0, 1'b0);
    run_vec("t3", 1, 2'd3, 4'hF, 1'b0, 1'b1);
    digit_mask = 4'b0100;
    run_vec("t3", 3, 2'd3, 4'hF, 1'b0, 1'b0);
    run_vec("t3", 1, 2'd2, 4'hF, 1'b1, 1'b1);
    run_vec("t3", 2, 2'd2, 4'hB, 1'b0, 1'b0);

    // 4: freeze at cnt=2 for 10 cycles; advance exactly 2 cycles after resume
    enable = 1'b0;
    run_vec("t4.frozen", 10, 2'd2, 4'hF, 1'b0, 1'b1);
    enable = 1'b1;
    run_vec("t4.resume", 1, 2'd2, 4'hB, 1'b0, 1'b0);
    run_vec("t4.adv",    1, 2'd2, 4'hF, 1'b1, 1'b1);

    // 4b: enable drops exactly at terminal count: no advance
    digit_mask = 4'b1111;
    run_vec("t4b", 3, 2'd2, 4'hB, 1'b0, 1'b0);
    enable = 1'b0;
    run_vec("t4b.tc_off", 2, 2'd2, 4'hF, 1'b0, 1'b1);
    enable = 1'b1;
    run_vec("t4b.adv", 1, 2'd3, 4'hF, 1'b0, 1'b1);
    run_vec("t4b.adv", 1, 2'd3, 4'h7, 1'b0, 1'b0);

    // 6: reset between clock edges takes effect before the next rising edge
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6.sel",    32'(digit_sel),   32'd0);
    check("t6.anode",  32'(anode),       32'hF);
    check("t6.blank",  32'(blank),       32'd1);
    check("t6.frame",  32'(frame_start), 32'd0);
    check("t6.sel3",   32'(digit_sel3),  32'd0);
    check("t6.anode3", 32'(anode3),      32'h7);
    @(negedge clk);
    reset = 1'b0;

    // 5: three digits, no blanking: 0,1,2,0 with an anode always lit
    for (int j = 1; j <= 12; j++) begin
      logic [1:0] exp_sel;
      logic [2:0] exp_an;
      @(negedge clk);
      exp_sel = 2'((j / 3) % 3);
      exp_an  = ~(3'b001 << exp_sel);
      check("t5.sel",   32'(digit_sel3),   32'(exp_sel));
      check("t5.anode", 32'(anode3),       32'(exp_an));
      check("t5.blank", 32'(blank3),       32'd0);
      check("t5.frame", 32'(frame_start3), 32'((j % 3 == 0) && (exp_sel == 2'd0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
